// File: rtl/cpu_bus_ctrl_if.sv
// cpu_bus_ctrl_if
//   Bus bundle between the 65C02 socket, the bus-cycle controller and the
//   ROM/RAM/IO targets. The controller connects through the master modport.
//   The CPU/target side (board glue or bench) connects through the slave
//   modport.
//   CPU side : cpu_addr, cpu_rwb, cpu_data_in -> ctrl;
//              cpu_data_out, cpu_data_oe, cpu_phi2, cpu_resb <- ctrl
//   Mem side : mem_addr, mem_wdata, mem_we, mem_re, rom/ram/io_cs <- ctrl;
//              rom/ram/io_rdata -> ctrl
interface cpu_bus_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_rwb;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_oe;
  logic        cpu_phi2;
  logic        cpu_resb;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        rom_cs;
  logic        ram_cs;
  logic        io_cs;
  logic [7:0]  rom_rdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  io_rdata;

  modport master (
    input  cpu_addr, cpu_rwb, cpu_data_in, rom_rdata, ram_rdata, io_rdata,
    output cpu_data_out, cpu_data_oe, cpu_phi2, cpu_resb,
           mem_addr, mem_wdata, mem_we, mem_re, rom_cs, ram_cs, io_cs
  );

  modport slave (
    output cpu_addr, cpu_rwb, cpu_data_in, rom_rdata, ram_rdata, io_rdata,
    input  cpu_data_out, cpu_data_oe, cpu_phi2, cpu_resb,
           mem_addr, mem_wdata, mem_we, mem_re, rom_cs, ram_cs, io_cs
  );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl
//   Bus-cycle controller for the 65C02 socket. It generates phi2 and the
//   power-on cpu_resb stretch, and decodes the CPU address into ROM (0xFFxx),
//   IO (0x7Fxx) and RAM (0x0000-0x7EFF) selects. It stretches phi2-high per
//   target to insert wait states, and registers read data back to the CPU.
//   Ports: clk_50 (all state on rising edge), reset (synchronous,
//   active-high), bus (cpu_bus_ctrl_if.master, all CPU and target signals).
module cpu_bus_ctrl #(
  parameter int unsigned PHI_HALF     = 12,
  parameter int unsigned ROM_WAIT     = 1,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned IO_WAIT      = 4,
  parameter int unsigned RESET_CYCLES = 8
) (
  input  logic                 clk_50,
  input  logic                 reset,
  cpu_bus_ctrl_if.master       bus
);

  typedef enum logic [1:0] {ST_RST, ST_PHI1, ST_PHI2} state_t;
  typedef enum logic [1:0] {TGT_NONE, TGT_ROM, TGT_RAM, TGT_IO} tgt_t;

  localparam logic [7:0] HALF_M1  = 8'(PHI_HALF - 1);
  localparam logic [7:0] ROM_LOAD = 8'(PHI_HALF - 1 + ROM_WAIT);
  localparam logic [7:0] RAM_LOAD = 8'(PHI_HALF - 1 + RAM_WAIT);
  localparam logic [7:0] IO_LOAD  = 8'(PHI_HALF - 1 + IO_WAIT);
  localparam logic [7:0] NONE_LOAD = HALF_M1;

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        last;

  tgt_t        dec_tgt, tgt;
  logic [7:0]  dec_load;
  logic [7:0]  rdata_mux;

  logic        rw;
  logic        resb;
  logic [15:0] rst_cnt;
  logic        first;
  logic        rom_cs_q, ram_cs_q, io_cs_q, re_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  dout_q;

  assign last = (cnt == '0);

  // Address decode of the live CPU address; used only on the last PHI1 clk.
  always_comb begin
    dec_tgt  = TGT_NONE;
    dec_load = NONE_LOAD;
    if (bus.cpu_addr[15:8] == 8'hFF) begin
      dec_tgt  = TGT_ROM;
      dec_load = ROM_LOAD;
    end else if (bus.cpu_addr[15:8] == 8'h7F) begin
      dec_tgt  = TGT_IO;
      dec_load = IO_LOAD;
    end else if (!bus.cpu_addr[15]) begin
      dec_tgt  = TGT_RAM;
      dec_load = RAM_LOAD;
    end
  end

  always_comb begin
    rdata_mux = 8'hFF;
    case (tgt)
      TGT_ROM: rdata_mux = bus.rom_rdata;
      TGT_RAM: rdata_mux = bus.ram_rdata;
      TGT_IO:  rdata_mux = bus.io_rdata;
      default: rdata_mux = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = last ? cnt : cnt - 8'd1;
    case (state)
      ST_RST: begin
        state_d = ST_PHI1;
        cnt_d   = HALF_M1;
      end
      ST_PHI1: begin
        if (last) begin
          state_d = ST_PHI2;
          cnt_d   = dec_load;
        end
      end
      ST_PHI2: begin
        if (last) begin
          state_d = ST_PHI1;
          cnt_d   = HALF_M1;
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = HALF_M1;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state <= ST_RST;
      cnt   <= HALF_M1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      resb     <= 1'b0;
      rst_cnt  <= 16'(RESET_CYCLES);
      rw       <= 1'b1;
      tgt      <= TGT_NONE;
      first    <= 1'b0;
      rom_cs_q <= 1'b0;
      ram_cs_q <= 1'b0;
      io_cs_q  <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= 8'hFF;
    end else begin
      if (state == ST_PHI1 && last) begin
        addr_q   <= bus.cpu_addr;
        rw       <= bus.cpu_rwb;
        wdata_q  <= bus.cpu_data_in;
        tgt      <= dec_tgt;
        rom_cs_q <= (dec_tgt == TGT_ROM);
        ram_cs_q <= (dec_tgt == TGT_RAM);
        io_cs_q  <= (dec_tgt == TGT_IO);
        re_q     <= bus.cpu_rwb && (dec_tgt != TGT_NONE);
        first    <= 1'b1;
      end
      if (state == ST_PHI2) begin
        first <= 1'b0;
        // Target data is valid one clk after cs/re, so skip the first clk.
        if (!first)
          dout_q <= rdata_mux;
        // CPU write data is only guaranteed during phi2 high; re-latch it
        // one clk before the strobe so it is stable while mem_we is high.
        if (cnt == 8'd1)
          wdata_q <= bus.cpu_data_in;
        if (last) begin
          rom_cs_q <= 1'b0;
          ram_cs_q <= 1'b0;
          io_cs_q  <= 1'b0;
          re_q     <= 1'b0;
          if (!resb) begin
            if (rst_cnt <= 16'd1) begin
              rst_cnt <= '0;
              resb    <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt - 16'd1;
            end
          end
        end
      end
    end
  end

  assign bus.cpu_phi2     = (state == ST_PHI2);
  assign bus.cpu_resb     = resb;
  assign bus.cpu_data_oe  = (state == ST_PHI2 && rw) ? '1 : '0;
  assign bus.cpu_data_out = dout_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_re       = re_q;
  assign bus.rom_cs       = rom_cs_q;
  assign bus.ram_cs       = ram_cs_q;
  assign bus.io_cs        = io_cs_q;
  // Decoded from registered state only, so it covers exactly the final
  // phi2-high clk and vanishes on the edge that samples reset.
  assign bus.mem_we       = (state == ST_PHI2) && last && !rw && resb &&
                            (tgt != TGT_NONE);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
module tb_cpu_bus_ctrl;
  logic clk_50 = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cpu_bus_ctrl_if bus ();

  cpu_bus_ctrl #(
    .PHI_HALF(12),
    .ROM_WAIT(1),
    .RAM_WAIT(0),
    .IO_WAIT(4),
    .RESET_CYCLES(8)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .bus(bus)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    logic [15:0] addr;
    logic        rwb;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [2:0]  cs;     // {rom, ram, io}
    int          hi;
    logic [7:0]  dout;
    int          we;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at the first negedge sample after phi2 fell.
  task automatic run_vec(input vec_t v, input int idx);
    int lo, hi, we_cnt, we_pos, cs_bad, oe_bad, re_bad;
    logic [15:0] we_addr;
    logic [7:0]  we_data;
    logic [7:0]  exp_oe;
    logic        exp_re;
    exp_oe = v.rwb ? 8'hFF : 8'h00;
    exp_re = v.rwb && (v.cs != 3'b000);
    bus.cpu_addr    = v.addr;
    bus.cpu_rwb     = v.rwb;
    bus.cpu_data_in = v.wdata ^ 8'h5A;   // real data only appears in phi2 high
    bus.rom_rdata   = (v.cs == 3'b100) ? v.rdata : ~v.rdata;
    bus.ram_rdata   = (v.cs == 3'b010) ? v.rdata : ~v.rdata;
    bus.io_rdata    = (v.cs == 3'b001) ? v.rdata : ~v.rdata;
    chk($sformatf("v%0d low_oe", idx), bus.cpu_data_oe, 8'h00);
    lo = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_50);
      if (bus.cpu_phi2) break;
      lo++;
    end
    chk($sformatf("v%0d low_len", idx), lo, 12);
    bus.cpu_data_in = v.wdata;
    hi = 0; we_cnt = 0; we_pos = 0; cs_bad = 0; oe_bad = 0; re_bad = 0;
    we_addr = '0; we_data = '0;
    for (int k = 0; k < 300; k++) begin
      if (!bus.cpu_phi2) break;
      hi++;
      if ({bus.rom_cs, bus.ram_cs, bus.io_cs} !== v.cs) cs_bad++;
      if (bus.cpu_data_oe !== exp_oe) oe_bad++;
      if (bus.mem_re !== exp_re) re_bad++;
      if (bus.mem_we === 1'b1) begin
        we_cnt++;
        we_pos  = hi;
        we_addr = bus.mem_addr;
        we_data = bus.mem_wdata;
      end
      @(negedge clk_50);
    end
    chk($sformatf("v%0d high_len", idx), hi, v.hi);
    chk($sformatf("v%0d cs_bad", idx), cs_bad, 0);
    chk($sformatf("v%0d oe_bad", idx), oe_bad, 0);
    chk($sformatf("v%0d re_bad", idx), re_bad, 0);
    chk($sformatf("v%0d we_cnt", idx), we_cnt, v.we);
    if (v.we != 0) begin
      chk($sformatf("v%0d we_pos", idx), we_pos, v.hi);
      chk($sformatf("v%0d we_addr", idx), we_addr, v.addr);
      chk($sformatf("v%0d we_data", idx), we_data, v.wdata);
    end
    chk($sformatf("v%0d dout", idx), bus.cpu_data_out, v.dout);
    chk($sformatf("v%0d cs_after", idx), {bus.rom_cs, bus.ram_cs, bus.io_cs}, 3'b000);
  endtask

  initial begin
    int falls, we_seen, hi;
    logic prev;
    vecs[0]  = '{16'h1234, 1'b1, 8'h00, 8'h5A, 3'b010, 12, 8'h5A, 0};
    vecs[1]  = '{16'hFFFC, 1'b1, 8'h00, 8'h00, 3'b100, 13, 8'h00, 0};
    vecs[2]  = '{16'h7F01, 1'b0, 8'hA5, 8'h3C, 3'b001, 16, 8'h3C, 1};
    vecs[3]  = '{16'h9000, 1'b1, 8'h00, 8'hFF, 3'b000, 12, 8'hFF, 0};
    vecs[4]  = '{16'h9000, 1'b0, 8'h77, 8'hFF, 3'b000, 12, 8'hFF, 0};
    vecs[5]  = '{16'h0042, 1'b0, 8'h11, 8'h22, 3'b010, 12, 8'h22, 1};
    vecs[6]  = '{16'h7F80, 1'b1, 8'h00, 8'hC3, 3'b001, 16, 8'hC3, 0};
    vecs[7]  = '{16'h7EFF, 1'b1, 8'h00, 8'h81, 3'b010, 12, 8'h81, 0};
    vecs[8]  = '{16'h8000, 1'b1, 8'h00, 8'hFF, 3'b000, 12, 8'hFF, 0};
    vecs[9]  = '{16'hFF00, 1'b0, 8'h99, 8'h66, 3'b100, 13, 8'h66, 1};
    vecs[10] = '{16'hFEFF, 1'b1, 8'h00, 8'hFF, 3'b000, 12, 8'hFF, 0};

    // A RAM write pending during the reset stretch must never strobe.
    reset           = 1'b1;
    bus.cpu_addr    = 16'h1234;
    bus.cpu_rwb     = 1'b0;
    bus.cpu_data_in = 8'hEE;
    bus.rom_rdata   = 8'h01;
    bus.ram_rdata   = 8'h02;
    bus.io_rdata    = 8'h03;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    chk("rst_phi2", bus.cpu_phi2, 1'b0);
    chk("rst_resb", bus.cpu_resb, 1'b0);
    chk("rst_cs", {bus.rom_cs, bus.ram_cs, bus.io_cs}, 3'b000);
    chk("rst_dout", bus.cpu_data_out, 8'hFF);
    chk("rst_oe", bus.cpu_data_oe, 8'h00);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    reset = 1'b0;

    falls = 0; we_seen = 0; prev = bus.cpu_phi2;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_50);
      if (prev && !bus.cpu_phi2) falls++;
      if (bus.mem_we === 1'b1) we_seen++;
      if (bus.cpu_resb) break;
      prev = bus.cpu_phi2;
    end
    chk("stretch_resb", bus.cpu_resb, 1'b1);
    chk("stretch_falls", falls, 8);
    chk("stretch_on_fall", {prev, bus.cpu_phi2}, 2'b10);
    chk("stretch_no_we", we_seen, 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset on the 5th phi2-high clk of an IO write.
    bus.cpu_addr    = 16'h7F01;
    bus.cpu_rwb     = 1'b0;
    bus.cpu_data_in = 8'hA5;
    we_seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_50);
      if (bus.cpu_phi2) break;
    end
    chk("mid_reached_high", bus.cpu_phi2, 1'b1);
    hi = 1;
    for (int k = 0; k < 4; k++) begin
      if (bus.mem_we === 1'b1) we_seen++;
      @(negedge clk_50);
      hi++;
    end
    chk("mid_hi5", hi, 5);
    if (bus.mem_we === 1'b1) we_seen++;
    reset = 1'b1;
    @(negedge clk_50);
    if (bus.mem_we === 1'b1) we_seen++;
    chk("mid_phi2", bus.cpu_phi2, 1'b0);
    chk("mid_resb", bus.cpu_resb, 1'b0);
    chk("mid_cs", {bus.rom_cs, bus.ram_cs, bus.io_cs}, 3'b000);
    chk("mid_no_we", we_seen, 0);
    reset = 1'b0;
    @(negedge clk_50);
    chk("mid_dout", bus.cpu_data_out, 8'hFF);
    chk("mid_resb_hold", bus.cpu_resb, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
